// File: rtl/pid_pkg.sv
// Shared definitions for the parametrised traction PID controller.
//   - pidState_e  : sequencer states, one cycle each (IDLE -> ERR -> MUL -> SUM -> OUT)
//   - DIR_*       : motor shield direction encodings {DIR_A, DIR_B}
//   - PWM_MAX_DEF : default saturation magnitude of the PWM command
//   - prodWidth / sumWidth : width helpers so products and the final sum never overflow
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        MUL,
        SUM,
        OUT
    } pidState_e;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    localparam int PWM_MAX_DEF = 249;

    // Full-precision width of a signed product of two signed operands.
    function automatic int prodWidth(input int aW, input int bW);
        return aW + bW;
    endfunction

    // Width that holds the sum of three signed terms without overflow.
    function automatic int sumWidth(input int pW, input int iW, input int dW);
        int m;
        m = pW;
        if (iW > m) m = iW;
        if (dW > m) m = dW;
        return m + 2;
    endfunction

endpackage

// File: rtl/pid_traccion_param_saturador.sv
// Combinational output stage of the traction PID: turns the scaled signed
// command u into a PWM magnitude, a direction pair and a saturation flag.
// Ports:
//   u_i   : signed scaled controller output (two's complement, U_W bits)
//   pwm_o : PWM magnitude, 0..PWM_MAX
//   dir_o : {DIR_A, DIR_B}; forward, reverse or brake
//   sat_o : high when |u| was clamped to PWM_MAX
module pid_saturador
    import pid_pkg::*;
#(
    parameter int U_W      = 55,
    parameter int PWM_W    = 8,
    parameter int PWM_MAX  = PWM_MAX_DEF,
    parameter int DEADBAND = 0
) (
    input  logic [U_W-1:0]   u_i,
    output logic [PWM_W-1:0] pwm_o,
    output logic [1:0]       dir_o,
    output logic             sat_o
);

    localparam logic [U_W-1:0]   MAX_U   = U_W'(PWM_MAX);
    localparam logic [PWM_W-1:0] MAX_PWM = PWM_W'(PWM_MAX);

    logic           uNeg;
    logic [U_W-1:0] mag;
    logic           inDeadband;

    assign uNeg = u_i[U_W-1];
    // u is bounded far below the most negative value, so negation cannot overflow.
    assign mag  = uNeg ? -u_i : u_i;

    // A zero deadband would make the comparison constant, so it is only built when used.
    generate
        if (DEADBAND > 0) begin : g_deadband
            localparam logic [U_W-1:0] DB_U = U_W'(DEADBAND);
            assign inDeadband = (mag < DB_U);
        end else begin : g_noDeadband
            assign inDeadband = 1'b0;
        end
    endgenerate

    // Clamp has priority over the deadband; zero or deadband commands brake the motor.
    always_comb begin
        pwm_o = '0;
        dir_o = DIR_BRAKE;
        sat_o = 1'b0;
        if (mag >= MAX_U) begin
            pwm_o = MAX_PWM;
            sat_o = 1'b1;
            dir_o = uNeg ? DIR_REV : DIR_FWD;
        end else if ((mag == '0) || inDeadband) begin
            pwm_o = '0;
            dir_o = DIR_BRAKE;
        end else begin
            pwm_o = mag[PWM_W-1:0];
            dir_o = uNeg ? DIR_REV : DIR_FWD;
        end
    end

endmodule

// File: rtl/pid_traccion_param.sv
// Parametrised traction RPM PID controller, one instance per wheel channel.
// A Sample_en strobe in IDLE starts a four-step sequence (ERR, MUL, SUM, OUT);
// the new PWM/direction/Saturado values appear together with a one-cycle Valid
// in OUT and hold until the next update.
// Ports:
//   Prescaler_clk, Reset_n      : control clock, asynchronous active-low reset
//   Sample_en                   : one-cycle strobe starting an update
//   SetPoint, RPM_Medidas       : signed setpoint and measured RPM
//   Gain_load, K_P_in/K_I_in/K_D_in : load new gains into the pending registers
//   COMANDO_PWM, DIR_A, DIR_B   : motor shield PWM magnitude and direction
//   Valid                       : one-cycle pulse on output update
//   Saturado                    : last update was clamped to PWM_MAX
//   Overrun                     : Sample_en arrived while a computation was in flight
module pid_traccion_param
    import pid_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int GAIN_W      = 16,
    parameter int ACC_W       = 36,
    parameter int SCALE_SHIFT = 7,
    parameter int PWM_W       = 8,
    parameter int PWM_MAX     = PWM_MAX_DEF,
    parameter int DEADBAND    = 0,
    parameter int K_P_RST     = 64,
    parameter int K_I_RST     = 8,
    parameter int K_D_RST     = 0
) (
    input  logic              Prescaler_clk,
    input  logic              Reset_n,
    input  logic              Sample_en,
    input  logic [DATA_W-1:0] SetPoint,
    input  logic [DATA_W-1:0] RPM_Medidas,
    input  logic              Gain_load,
    input  logic [GAIN_W-1:0] K_P_in,
    input  logic [GAIN_W-1:0] K_I_in,
    input  logic [GAIN_W-1:0] K_D_in,
    output logic [PWM_W-1:0]  COMANDO_PWM,
    output logic              DIR_A,
    output logic              DIR_B,
    output logic              Valid,
    output logic              Saturado,
    output logic              Overrun
);

    localparam int ERR_W = DATA_W + 1;
    localparam int DIF_W = DATA_W + 2;
    localparam int KS_W  = GAIN_W + 1;
    localparam int P_W   = prodWidth(KS_W, ERR_W);
    localparam int I_W   = prodWidth(KS_W, ACC_W);
    localparam int D_W   = prodWidth(KS_W, DIF_W);
    localparam int S_W   = sumWidth(P_W, I_W, D_W);

    // Integrator limits are symmetric: +/-(2^(ACC_W-1)-1).
    localparam logic signed [ACC_W:0]   LIM_HI   = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   LIM_LO   = -LIM_HI;
    localparam logic signed [ACC_W-1:0] LIM_HI_A = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LIM_LO_A = -LIM_HI_A;

    pidState_e state_q;

    logic [DATA_W-1:0] sp_q, meas_q;
    logic [GAIN_W-1:0] kp_q, ki_q, kd_q;
    logic [GAIN_W-1:0] kpPend_q, kiPend_q, kdPend_q;

    logic signed [ERR_W-1:0] err_q, errPrev_q, err_d;
    logic signed [DIF_W-1:0] dif_q, dif_d;
    logic signed [ACC_W-1:0] integ_q, integ_d;
    logic signed [P_W-1:0]   p_q, p_d;
    logic signed [I_W-1:0]   i_q, i_d;
    logic signed [D_W-1:0]   dd_q, dd_d;
    logic signed [S_W-1:0]   s_d, u_d;
    logic signed [ACC_W:0]   iSum;
    logic signed [KS_W-1:0]  kpS, kiS, kdS;

    logic [PWM_W-1:0] pwm_q, satPwm;
    logic [1:0]       dir_q, satDir;
    logic             valid_q, sat_q, satFlag;
    logic             spZero, uNeg, uPos, errPos, errNeg, windup, hiOv, loOv;

    // Datapath for every stage; each stage's result is captured by the sequencer below.
    // Gains are unsigned, so a zero MSB turns them into non-negative signed operands.
    always_comb begin
        err_d = $signed({sp_q[DATA_W-1], sp_q}) - $signed({meas_q[DATA_W-1], meas_q});
        dif_d = DIF_W'(err_d) - DIF_W'(errPrev_q);

        kpS  = $signed({1'b0, kp_q});
        kiS  = $signed({1'b0, ki_q});
        kdS  = $signed({1'b0, kd_q});
        p_d  = P_W'(kpS) * P_W'(err_q);
        i_d  = I_W'(kiS) * I_W'(integ_q);
        dd_d = D_W'(kdS) * D_W'(dif_q);

        s_d  = S_W'(p_q) + S_W'(i_q) + S_W'(dd_q);
        u_d  = s_d >>> SCALE_SHIFT;
    end

    pid_saturador #(
        .U_W      (S_W),
        .PWM_W    (PWM_W),
        .PWM_MAX  (PWM_MAX),
        .DEADBAND (DEADBAND)
    ) u_saturador (
        .u_i   (u_d),
        .pwm_o (satPwm),
        .dir_o (satDir),
        .sat_o (satFlag)
    );

    // Next integrator value: clamped accumulate, frozen while the output is pinned
    // at the limit and the error would push it further in the same direction.
    always_comb begin
        spZero  = (sp_q == '0);
        uNeg    = u_d[S_W-1];
        uPos    = !uNeg && (u_d != '0);
        errNeg  = err_q[ERR_W-1];
        errPos  = !errNeg && (err_q != '0);
        windup  = satFlag && ((errPos && uPos) || (errNeg && uNeg));

        iSum    = (ACC_W+1)'(integ_q) + (ACC_W+1)'(err_q);
        hiOv    = (iSum > LIM_HI);
        loOv    = (iSum < LIM_LO);

        integ_d = integ_q;
        if (!windup) begin
            if (hiOv)      integ_d = LIM_HI_A;
            else if (loOv) integ_d = LIM_LO_A;
            else           integ_d = iSum[ACC_W-1:0];
        end
    end

    // Sequencer and all registered state. Results are committed on the SUM->OUT edge
    // so that outputs and Valid become visible together during OUT; the product stage
    // has already consumed the old integrator, so u never sees its own update.
    always_ff @(posedge Prescaler_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            sp_q      <= '0;
            meas_q    <= '0;
            kp_q      <= GAIN_W'(K_P_RST);
            ki_q      <= GAIN_W'(K_I_RST);
            kd_q      <= GAIN_W'(K_D_RST);
            kpPend_q  <= GAIN_W'(K_P_RST);
            kiPend_q  <= GAIN_W'(K_I_RST);
            kdPend_q  <= GAIN_W'(K_D_RST);
            err_q     <= '0;
            errPrev_q <= '0;
            dif_q     <= '0;
            integ_q   <= '0;
            p_q       <= '0;
            i_q       <= '0;
            dd_q      <= '0;
            pwm_q     <= '0;
            dir_q     <= DIR_BRAKE;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (Gain_load) begin
                kpPend_q <= K_P_in;
                kiPend_q <= K_I_in;
                kdPend_q <= K_D_in;
            end
            case (state_q)
                IDLE: begin
                    if (Sample_en) begin
                        sp_q    <= SetPoint;
                        meas_q  <= RPM_Medidas;
                        kp_q    <= Gain_load ? K_P_in : kpPend_q;
                        ki_q    <= Gain_load ? K_I_in : kiPend_q;
                        kd_q    <= Gain_load ? K_D_in : kdPend_q;
                        state_q <= ERR;
                    end
                end
                ERR: begin
                    err_q   <= err_d;
                    dif_q   <= dif_d;
                    state_q <= MUL;
                end
                MUL: begin
                    p_q     <= p_d;
                    i_q     <= i_d;
                    dd_q    <= dd_d;
                    state_q <= SUM;
                end
                SUM: begin
                    valid_q <= 1'b1;
                    if (spZero) begin
                        pwm_q     <= '0;
                        dir_q     <= DIR_BRAKE;
                        sat_q     <= 1'b0;
                        integ_q   <= '0;
                        errPrev_q <= '0;
                    end else begin
                        pwm_q     <= satPwm;
                        dir_q     <= satDir;
                        sat_q     <= satFlag;
                        integ_q   <= integ_d;
                        errPrev_q <= err_q;
                    end
                    state_q <= OUT;
                end
                OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign COMANDO_PWM = pwm_q;
    assign DIR_A       = dir_q[1];
    assign DIR_B       = dir_q[0];
    assign Valid       = valid_q;
    assign Saturado    = sat_q;
    // Flagged in the same cycle as the rejected strobe.
    assign Overrun     = Sample_en && (state_q != IDLE);

endmodule

// File: tb/tb_pid_traccion_param.sv
// Directed self-checking bench for pid_traccion_param with hand-computed expectations.
module tb_pid_traccion_param;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sampleEn;
    logic        gainLoad;
    logic [15:0] setPoint, rpm, kpIn, kiIn, kdIn;
    logic [7:0]  pwm;
    logic        dirA, dirB, valid, sat, overrun;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pid_traccion_param dut (
        .Prescaler_clk (clk),
        .Reset_n       (rstN),
        .Sample_en     (sampleEn),
        .SetPoint      (setPoint),
        .RPM_Medidas   (rpm),
        .Gain_load     (gainLoad),
        .K_P_in        (kpIn),
        .K_I_in        (kiIn),
        .K_D_in        (kdIn),
        .COMANDO_PWM   (pwm),
        .DIR_A         (dirA),
        .DIR_B         (dirB),
        .Valid         (valid),
        .Saturado      (sat),
        .Overrun       (overrun)
    );

    // Pending-gain load, one cycle wide, driven between clock edges.
    task automatic loadGains(input logic [15:0] kp, input logic [15:0] ki, input logic [15:0] kd);
        @(negedge clk);
        kpIn = kp; kiIn = ki; kdIn = kd; gainLoad = 1'b1;
        @(negedge clk);
        gainLoad = 1'b0;
    endtask

    // One sample: strobe, then wait (bounded) for Valid; lat counts edges from the strobe, -1 on timeout.
    task automatic runSample(input logic [15:0] sp, input logic [15:0] meas, input bit withLoad,
                             output int lat, output logic [7:0] pwmObs, output logic [1:0] dirObs,
                             output logic satObs);
        @(negedge clk);
        setPoint = sp; rpm = meas; sampleEn = 1'b1; gainLoad = withLoad;
        @(negedge clk);
        sampleEn = 1'b0; gainLoad = 1'b0; lat = 1;
        while (valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (valid !== 1'b1) lat = -1;
        pwmObs = pwm; dirObs = {dirA, dirB}; satObs = sat;
    endtask

    task automatic test_reset();
        rstN = 1'b0; sampleEn = 1'b0; gainLoad = 1'b0;
        setPoint = '0; rpm = '0; kpIn = '0; kiIn = '0; kdIn = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pwm, dirA, dirB, valid, sat, overrun} !== {8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("[TB] FAIL reset_values: pwm=%0d dir=%b%b valid=%b sat=%b ovr=%b, expected pwm=0 dir=11 valid=0 sat=0 ovr=0",
                     pwm, dirA, dirB, valid, sat, overrun);
        else passes++;
        rstN = 1'b1;
    endtask

    task automatic test_forward_reverse();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        loadGains(16'd64, 16'd0, 16'd0);
        runSample(16'd100, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (lat !== 4 || p !== 8'd50 || d !== 2'b10 || s !== 1'b0)
            $display("[TB] FAIL fwd_100: lat=%0d pwm=%0d dir=%b sat=%b, expected lat=4 pwm=50 dir=10 sat=0", lat, p, d, s);
        else passes++;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || pwm !== 8'd50)
            $display("[TB] FAIL hold_after_valid: valid=%b pwm=%0d, expected valid=0 pwm=50", valid, pwm);
        else passes++;
        runSample(-16'sd100, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (lat !== 4 || p !== 8'd50 || d !== 2'b01 || s !== 1'b0)
            $display("[TB] FAIL rev_100: lat=%0d pwm=%0d dir=%b sat=%b, expected lat=4 pwm=50 dir=01 sat=0", lat, p, d, s);
        else passes++;
        // -192 >>> 7 floors to -2
        runSample(-16'sd3, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd2 || d !== 2'b01 || s !== 1'b0)
            $display("[TB] FAIL rev_floor: pwm=%0d dir=%b sat=%b, expected pwm=2 dir=01 sat=0", p, d, s);
        else passes++;
    endtask

    task automatic test_pwm_boundary();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        loadGains(16'd128, 16'd0, 16'd0);
        runSample(16'd249, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd249 || d !== 2'b10 || s !== 1'b1)
            $display("[TB] FAIL at_pwm_max: pwm=%0d dir=%b sat=%b, expected pwm=249 dir=10 sat=1", p, d, s);
        else passes++;
        runSample(16'd300, 16'd52, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd248 || d !== 2'b10 || s !== 1'b0)
            $display("[TB] FAIL below_pwm_max: pwm=%0d dir=%b sat=%b, expected pwm=248 dir=10 sat=0", p, d, s);
        else passes++;
    endtask

    task automatic test_anti_windup_integrator();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        logic [7:0] expPwm [3];
        logic [1:0] expDir [3];
        loadGains(16'd64, 16'd8, 16'd0);
        runSample(16'd0, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd0 || d !== 2'b11 || s !== 1'b0)
            $display("[TB] FAIL sp_zero_clear: pwm=%0d dir=%b sat=%b, expected pwm=0 dir=11 sat=0", p, d, s);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            runSample(16'd1000, 16'd0, 1'b0, lat, p, d, s);
            checks++;
            if (p !== 8'd249 || d !== 2'b10 || s !== 1'b1)
                $display("[TB] FAIL saturate_%0d: pwm=%0d dir=%b sat=%b, expected pwm=249 dir=10 sat=1", k, p, d, s);
            else passes++;
        end
        // Integrator must still be 0 here, so the first pure-I sample brakes.
        loadGains(16'd0, 16'd8, 16'd0);
        expPwm[0] = 8'd0; expPwm[1] = 8'd1; expPwm[2] = 8'd2;
        expDir[0] = 2'b11; expDir[1] = 2'b10; expDir[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            runSample(16'd16, 16'd0, 1'b0, lat, p, d, s);
            checks++;
            if (p !== expPwm[k] || d !== expDir[k] || s !== 1'b0)
                $display("[TB] FAIL integ_step_%0d: pwm=%0d dir=%b sat=%b, expected pwm=%0d dir=%b sat=0",
                         k, p, d, s, expPwm[k], expDir[k]);
            else passes++;
        end
        runSample(16'd0, 16'd50, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd0 || d !== 2'b11 || s !== 1'b0)
            $display("[TB] FAIL sp_zero_brake: pwm=%0d dir=%b sat=%b, expected pwm=0 dir=11 sat=0", p, d, s);
        else passes++;
        runSample(16'd16, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd0 || d !== 2'b11)
            $display("[TB] FAIL integ_cleared: pwm=%0d dir=%b, expected pwm=0 dir=11", p, d);
        else passes++;
    endtask

    task automatic test_derivative();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        // err_prev is 16 from the last sample
        loadGains(16'd0, 16'd0, 16'd128);
        runSample(16'd40, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd24 || d !== 2'b10)
            $display("[TB] FAIL deriv_rise: pwm=%0d dir=%b, expected pwm=24 dir=10", p, d);
        else passes++;
        runSample(16'd40, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd0 || d !== 2'b11)
            $display("[TB] FAIL deriv_steady: pwm=%0d dir=%b, expected pwm=0 dir=11", p, d);
        else passes++;
        runSample(16'd10, 16'd30, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd60 || d !== 2'b01)
            $display("[TB] FAIL deriv_fall: pwm=%0d dir=%b, expected pwm=60 dir=01", p, d);
        else passes++;
    endtask

    task automatic test_gain_coincident();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        // Pending gains are (0,0,128); loading (128,0,0) with the strobe must apply at once.
        kpIn = 16'd128; kiIn = 16'd0; kdIn = 16'd0;
        runSample(16'd100, 16'd0, 1'b1, lat, p, d, s);
        checks++;
        if (p !== 8'd100 || d !== 2'b10)
            $display("[TB] FAIL gain_coincident: pwm=%0d dir=%b, expected pwm=100 dir=10", p, d);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        int ovCnt; int vCnt;
        loadGains(16'd64, 16'd0, 16'd0);
        ovCnt = 0; vCnt = 0; p = '0; d = '0;
        @(negedge clk);
        setPoint = 16'd100; rpm = 16'd0; sampleEn = 1'b1;
        @(negedge clk);
        if (overrun === 1'b1) ovCnt++;
        sampleEn = 1'b0;
        @(negedge clk);
        if (overrun === 1'b1) ovCnt++;
        kpIn = 16'd128; kiIn = 16'd0; kdIn = 16'd0; gainLoad = 1'b1;
        @(negedge clk);
        gainLoad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (overrun === 1'b1) ovCnt++;
            if (valid === 1'b1) begin
                vCnt++;
                p = pwm; d = {dirA, dirB};
            end
        end
        checks++;
        if (ovCnt !== 1 || vCnt !== 1)
            $display("[TB] FAIL overrun_pulses: overrun=%0d valid=%0d, expected overrun=1 valid=1", ovCnt, vCnt);
        else passes++;
        checks++;
        if (p !== 8'd50 || d !== 2'b10)
            $display("[TB] FAIL inflight_gain: pwm=%0d dir=%b, expected pwm=50 dir=10", p, d);
        else passes++;
        runSample(16'd100, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd100 || d !== 2'b10)
            $display("[TB] FAIL next_gain: pwm=%0d dir=%b, expected pwm=100 dir=10", p, d);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] p; logic [1:0] d; logic s;
        int vCnt;
        @(negedge clk);
        setPoint = 16'd100; rpm = 16'd0; sampleEn = 1'b1;
        @(negedge clk);
        sampleEn = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checks++;
        if ({pwm, dirA, dirB, valid, sat} !== {8'd0, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL reset_mid_values: pwm=%0d dir=%b%b valid=%b sat=%b, expected pwm=0 dir=11 valid=0 sat=0",
                     pwm, dirA, dirB, valid, sat);
        else passes++;
        vCnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid === 1'b1) vCnt++;
        end
        rstN = 1'b1;
        checks++;
        if (vCnt !== 0)
            $display("[TB] FAIL reset_mid_valid: valid pulses=%0d, expected 0", vCnt);
        else passes++;
        // Reset gains are Kp=64 Ki=8: 6400/128 = 50, then (6400+800)/128 = 56
        runSample(16'd100, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (lat !== 4 || p !== 8'd50 || d !== 2'b10 || s !== 1'b0)
            $display("[TB] FAIL after_reset_1: lat=%0d pwm=%0d dir=%b sat=%b, expected lat=4 pwm=50 dir=10 sat=0", lat, p, d, s);
        else passes++;
        runSample(16'd100, 16'd0, 1'b0, lat, p, d, s);
        checks++;
        if (p !== 8'd56 || d !== 2'b10)
            $display("[TB] FAIL after_reset_2: pwm=%0d dir=%b, expected pwm=56 dir=10", p, d);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_forward_reverse();
        test_pwm_boundary();
        test_anti_windup_integrator();
        test_derivative();
        test_gain_coincident();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
